// File: rtl/fas_pkg.sv
// Shared constants and FSM state type for the FFT peak reader and its helpers.
package fas_pkg;

  localparam int unsigned NUM_BINS = 16;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned BIN_W    = 4;
  localparam int unsigned MAG_W    = 2 * DATA_W;

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDone
  } fas_state_t;

endpackage

// File: rtl/fas_mag_sq.sv
// Combinational squared magnitude of one complex sample: re*re + im*im, unsigned, no saturation.
module fas_mag_sq
  import fas_pkg::*;
(
  input  logic signed [DATA_W-1:0] re,
  input  logic signed [DATA_W-1:0] im,
  output logic        [MAG_W-1:0]  mag
);

  logic signed [MAG_W-1:0] re_x;
  logic signed [MAG_W-1:0] im_x;
  logic signed [MAG_W-1:0] re_sq;
  logic signed [MAG_W-1:0] im_sq;

  assign re_x  = MAG_W'(re);
  assign im_x  = MAG_W'(im);
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;
  // Each square is at most 2^30, so the unsigned sum (at most 2^31) never overflows.
  assign mag   = $unsigned(re_sq) + $unsigned(im_sq);

endmodule

// File: rtl/fft_peak_reader.sv
// Captures a 16-bin FFT frame, streams it out bin by bin with valid/ready, and reports the
// index of the largest-magnitude bin at end of frame.
module fft_peak_reader
  import fas_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fft_valid,
  input  logic [31:0]              fft_d0,
  input  logic [31:0]              fft_d1,
  input  logic [31:0]              fft_d2,
  input  logic [31:0]              fft_d3,
  input  logic [31:0]              fft_d4,
  input  logic [31:0]              fft_d5,
  input  logic [31:0]              fft_d6,
  input  logic [31:0]              fft_d7,
  input  logic [31:0]              fft_d8,
  input  logic [31:0]              fft_d9,
  input  logic [31:0]              fft_d10,
  input  logic [31:0]              fft_d11,
  input  logic [31:0]              fft_d12,
  input  logic [31:0]              fft_d13,
  input  logic [31:0]              fft_d14,
  input  logic [31:0]              fft_d15,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [BIN_W-1:0]         out_bin,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic [MAG_W-1:0]         out_mag,
  output logic                     done,
  output logic [BIN_W-1:0]         freq,
  output logic                     overrun
);

  fas_state_t       state_q;
  logic [BIN_W-1:0] k_q;
  logic [MAG_W-1:0] max_q;
  logic [BIN_W-1:0] peak_q;
  logic [BIN_W-1:0] freq_q;
  logic             overrun_q;
  logic [31:0]      frame_q [NUM_BINS];
  logic [31:0]      fft_in  [NUM_BINS];

  logic [31:0]      cur;
  logic             better;
  logic [BIN_W-1:0] peak_nxt;

  assign fft_in = '{fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
                    fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15};

  assign cur    = frame_q[k_q];
  assign out_re = cur[31:16];
  assign out_im = cur[15:0];

  fas_mag_sq u_mag_sq (
    .re  (out_re),
    .im  (out_im),
    .mag (out_mag)
  );

  // Bin 0 seeds the running maximum; later bins must be strictly larger, so ties keep the lower index.
  assign better   = (k_q == '0) || (out_mag > max_q);
  assign peak_nxt = better ? k_q : peak_q;

  assign out_valid = (state_q == StStream);
  assign done      = (state_q == StDone);
  assign out_bin   = k_q;
  assign freq      = freq_q;
  assign overrun   = overrun_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      k_q       <= '0;
      max_q     <= '0;
      peak_q    <= '0;
      freq_q    <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_BINS; i++) begin
        frame_q[i] <= '0;
      end
    end else begin
      // Frames arriving while busy are dropped and flagged.
      overrun_q <= fft_valid && (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (fft_valid) begin
            for (int i = 0; i < NUM_BINS; i++) begin
              frame_q[i] <= fft_in[i];
            end
            k_q     <= '0;
            max_q   <= '0;
            peak_q  <= '0;
            state_q <= StStream;
          end
        end
        StStream: begin
          if (out_ready) begin
            if (better) begin
              max_q  <= out_mag;
              peak_q <= k_q;
            end
            if (k_q == LAST_BIN) begin
              freq_q  <= peak_nxt;
              state_q <= StDone;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_peak_reader.sv
// Scoreboard bench for fft_peak_reader: stimulus pushes expected beats/peaks, a monitor checks them.
module tb_fft_peak_reader;

  logic        clk;
  logic        rst;
  logic        fft_valid;
  logic [31:0] fd [16];
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  out_bin;
  logic signed [15:0] out_re;
  logic signed [15:0] out_im;
  logic [31:0] out_mag;
  logic        done;
  logic [3:0]  freq;
  logic        overrun;

  fft_peak_reader dut (
    .clk       (clk),
    .rst       (rst),
    .fft_valid (fft_valid),
    .fft_d0    (fd[0]),
    .fft_d1    (fd[1]),
    .fft_d2    (fd[2]),
    .fft_d3    (fd[3]),
    .fft_d4    (fd[4]),
    .fft_d5    (fd[5]),
    .fft_d6    (fd[6]),
    .fft_d7    (fd[7]),
    .fft_d8    (fd[8]),
    .fft_d9    (fd[9]),
    .fft_d10   (fd[10]),
    .fft_d11   (fd[11]),
    .fft_d12   (fd[12]),
    .fft_d13   (fd[13]),
    .fft_d14   (fd[14]),
    .fft_d15   (fd[15]),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_bin   (out_bin),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_mag   (out_mag),
    .done      (done),
    .freq      (freq),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  bin;
    logic [15:0] re;
    logic [15:0] im;
    logic [31:0] mag;
  } beat_t;

  beat_t exp_q[$];
  int    exp_freq_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int xfer_cnt = 0;
  int last_xfer_cyc = 0;
  int ovr_cnt = 0;

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mag_of(input logic [31:0] w);
    longint re;
    longint im;
    re = longint'($signed(w[31:16]));
    im = longint'($signed(w[15:0]));
    return 32'(re * re + im * im);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    logic        stall_prev;
    logic [84:0] held;
    beat_t       b;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev)
          check("stall_hold", {43'd0, out_valid, out_bin, out_re, out_im, out_mag},
                {43'd0, held});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", {124'd0, out_bin}, 128'hFFFF);
          end else begin
            b = exp_q.pop_front();
            check("beat", {60'd0, out_bin, out_re, out_im, out_mag},
                  {60'd0, b.bin, b.re, b.im, b.mag});
          end
          xfer_cnt++;
          last_xfer_cyc = cyc;
        end
        stall_prev = out_valid && !out_ready;
        held = {out_valid, out_bin, out_re, out_im, out_mag};
        if (done) begin
          if (exp_freq_q.size() == 0) check("unexpected_done", {124'd0, freq}, 128'hFFFF);
          else check("freq", {124'd0, freq}, 128'(exp_freq_q.pop_front()));
          done_cnt++;
          done_cyc = cyc;
        end
        if (overrun) ovr_cnt++;
      end
    end
  end

  // Push expectations and strobe fft_valid; returns with start = cycle index right after edge N.
  task automatic send(input int efreq, output int start);
    beat_t b;
    for (int i = 0; i < 16; i++) begin
      b.bin = 4'(i);
      b.re  = fd[i][31:16];
      b.im  = fd[i][15:0];
      b.mag = mag_of(fd[i]);
      exp_q.push_back(b);
    end
    exp_freq_q.push_back(efreq);
    fft_valid = 1'b1;
    @(posedge clk);
    #1;
    fft_valid = 1'b0;
    start = cyc;
  endtask

  task automatic wait_done(input int base, input string nm);
    int i;
    for (i = 0; i < 80; i++) begin
      if (done_cnt > base) break;
      @(posedge clk);
      #1;
    end
    if (done_cnt <= base) check({nm, "_done_timeout"}, 128'(done_cnt), 128'(base + 1));
  endtask

  int s;
  int base;
  int x0;
  int o0;

  initial begin
    rst = 1'b0;
    fft_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) fd[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {124'd0, out_valid, done, overrun, 1'b0}, 128'd0);
    check("rst_data", {60'd0, out_bin, out_re, out_im, out_mag}, 128'd0);
    check("rst_freq", {124'd0, freq}, 128'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single peak at bin 1, continuous ready, latency check.
    for (int i = 0; i < 16; i++) fd[i] = 32'h00010001;
    fd[1] = 32'h04000300;
    base = done_cnt;
    send(1, s);
    exp_q[exp_q.size() - 15].mag = 32'h00190000;
    check("first_beat", {123'd0, out_valid, out_bin}, {123'd0, 1'b1, 4'd0});
    wait_done(base, "peak1");
    check("done_latency", 128'(done_cyc - s), 128'd16);

    // Tie between bins 3 and 12 keeps the lower index.
    for (int i = 0; i < 16; i++) fd[i] = 32'h0;
    fd[3] = 32'h01000000;
    fd[12] = 32'h01000000;
    base = done_cnt;
    send(3, s);
    wait_done(base, "tie");

    // Full-scale magnitudes.
    for (int i = 0; i < 15; i++) fd[i] = 32'h7FFF0000;
    fd[15] = 32'h80008000;
    base = done_cnt;
    send(15, s);
    for (int i = 1; i <= 16; i++)
      exp_q[exp_q.size() - i].mag = (i == 1) ? 32'h80000000 : 32'h3FFF0001;
    wait_done(base, "fullscale");

    // Back-pressure: out_ready toggles every cycle.
    for (int i = 0; i < 16; i++) fd[i] = {16'(i), 16'h0};
    fd[9] = 32'h00200010;
    out_ready = 1'b0;
    base = done_cnt;
    x0 = xfer_cnt;
    send(9, s);
    for (int i = 0; i < 80; i++) begin
      if (done_cnt > base) break;
      @(posedge clk);
      #1;
      out_ready = ~out_ready;
    end
    if (done_cnt <= base) check("toggle_done_timeout", 128'(done_cnt), 128'(base + 1));
    check("toggle_xfers", 128'(xfer_cnt - x0), 128'd16);
    check("toggle_done_gap", 128'(done_cyc - last_xfer_cyc), 128'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Overrun: a second frame during STREAM is dropped.
    for (int i = 0; i < 16; i++) fd[i] = {16'(i), 16'(i)};
    fd[7] = 32'h0100FF00;
    base = done_cnt;
    o0 = ovr_cnt;
    send(7, s);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 16; i++) fd[i] = 32'h7FFF7FFF;
    fft_valid = 1'b1;
    @(posedge clk);
    #1;
    fft_valid = 1'b0;
    wait_done(base, "overrun");
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("overrun_cycles", 128'(ovr_cnt - o0), 128'd1);
    check("overrun_no_stream", {127'd0, out_valid}, 128'd0);

    // Reset in the middle of STREAM.
    for (int i = 0; i < 16; i++) fd[i] = {16'(i), 16'h0};
    send(15, s);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b0;
    exp_q.delete();
    exp_freq_q.delete();
    #1;
    check("midrst_out", {125'd0, out_valid, done, 1'b0}, 128'd0);
    check("midrst_freq", {124'd0, freq}, 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) fd[i] = 32'h00010001;
    fd[2] = 32'h00050000;
    base = done_cnt;
    send(2, s);
    check("post_rst_bin0", {123'd0, out_valid, out_bin}, {123'd0, 1'b1, 4'd0});
    wait_done(base, "post_rst");

    repeat (3) @(posedge clk);
    #1;
    check("beats_drained", 128'(exp_q.size()), 128'd0);
    check("freqs_drained", 128'(exp_freq_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_peak_reader.md
FFT_PEAK_READER -- requirements
Module: fft_peak_reader

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port fft_valid, input, 1 bit: one-cycle strobe; frame present on fft_d0..fft_d15.
REQ-004 SHALL have ports fft_d0..fft_d15, input, 32 bits each: bin k; [31:16] signed real, [15:0] signed imaginary.
REQ-005 SHALL have port out_ready, input, 1 bit: downstream accepts the current beat.
REQ-006 SHALL have port out_valid, output, 1 bit: out_bin, out_re, out_im and out_mag are valid.
REQ-007 SHALL have port out_bin, output, 4 bits: index of the presented bin.
REQ-008 SHALL have ports out_re and out_im, output, 16 bits signed each: real and imaginary parts of the presented bin.
REQ-009 SHALL have port out_mag, output, 32 bits unsigned: re*re + im*im of the presented bin.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at end of frame.
REQ-011 SHALL have port freq, output, 4 bits: peak-magnitude bin index; held from the done cycle until the next done.
REQ-012 SHALL have port overrun, output, 1 bit: one-cycle pulse; a frame was dropped.

Function
REQ-013 SHALL implement states IDLE, STREAM and DONE.
REQ-014 In IDLE, fft_valid=1 SHALL capture all 16 bins into an internal frame buffer, clear the beat index and running maximum, and go to STREAM.
REQ-015 In STREAM, out_valid SHALL be 1 and SHALL present buffer entry k with out_bin=k.
REQ-016 A beat SHALL transfer when out_valid and out_ready are both 1; on transfer, k SHALL increment.
REQ-017 While out_valid=1 and out_ready=0, all out_* signals SHALL hold stable.
REQ-018 On each transfer, if out_mag is strictly greater than the running maximum, the running maximum and peak index SHALL update; on a tie the lower index is kept.
REQ-019 Bin 0 SHALL initialise the maximum unconditionally.
REQ-020 The transfer of k=15 SHALL move the FSM to DONE without wrapping k.
REQ-021 In DONE, done=1 and freq=peak index SHALL hold for exactly one cycle, and out_valid SHALL be 0; the next state SHALL be IDLE.
REQ-022 Latency with out_ready held at 1: fft_valid sampled at edge N gives bin 0 presented in cycle N+1, bin 15 in cycle N+16, and done in cycle N+17.
REQ-023 In STREAM or DONE, fft_valid=1 SHALL pulse overrun for one cycle and drop the frame; the buffer, k and the maximum are unaffected.
REQ-024 Magnitude SHALL be computed full-width without saturation: each square is at most 2^30, and the sum is at most 2^31, which fits in 32 bits unsigned.
REQ-025 out_mag SHALL be combinational from the presented buffer entry; no extra pipeline stage.

Reset
REQ-026 rst=0 SHALL at any time force state IDLE, k=0, maximum=0 and peak index=0, and discard any partial frame.
REQ-027 Reset values SHALL be out_valid=0, out_bin=0, out_re=0, out_im=0, done=0, freq=0 and overrun=0; out_mag follows the cleared buffer and reads 0.
REQ-028 Release of rst SHALL be followed by IDLE and acceptance of the first fft_valid seen at a subsequent rising edge.

Structure
REQ-029 Shared package fas_pkg SHALL hold NUM_BINS=16, DATA_W=16, BIN_W=4 and the FSM state typedef.
REQ-030 The sub-module fas_mag_sq (combinational, signed 16x16 squares summed to 32 bits) SHALL compute out_mag and be reusable by the analysis stage.

Verification
REQ-031 Bench SHALL cover: rst low mid-STREAM -> out_valid=0, done=0, freq=0 immediately; after release, the next frame streams from bin 0.
REQ-032 Bench SHALL cover: all bins 0x00010001 except bin 1=0x04000300, out_ready=1 -> 16 beats in order, bin 1 out_mag=0x00190000, done at N+17, freq=1.
REQ-033 Bench SHALL cover: bins 3 and 12 both 0x01000000, all others 0 -> freq=3 (tie keeps lower index).
REQ-034 Bench SHALL cover: bins 0..14=0x7FFF0000 (mag 0x3FFF0001) and bin 15=0x80008000 -> bin 15 out_mag=0x80000000, freq=15.
REQ-035 Bench SHALL cover: out_ready toggled every cycle -> outputs stable while stalled, exactly 16 transfers, done one cycle after the 16th transfer.
REQ-036 Bench SHALL cover: second fft_valid during STREAM -> overrun pulse of 1 cycle, original frame completes unchanged, second frame never streamed.
